// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcode/funct encodings and mux selects for the MIPS control FSM
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_MEM_ADDR, S_LW_ACCESS, S_LW_WAIT, S_LW_WB,
    S_SW_ACCESS, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP,
    S_JAL_LINK, S_JAL_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;

  localparam logic [5:0] ALU_OP_RTYPE = 6'h00;
  localparam logic [5:0] ALU_OP_ADD   = 6'h09;
  localparam logic [5:0] ALU_OP_PASSA = 6'h3E;

  localparam logic       SRC_A_PC       = 1'b0;
  localparam logic       SRC_A_REG      = 1'b1;
  localparam logic [1:0] SRC_B_REG      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_SEXT     = 2'b10;
  localparam logic [1:0] SRC_B_SEXT_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

  function automatic logic is_logical_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_SLTIU) || is_logical_imm(op);
  endfunction

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_HALT) || is_branch_op(op) || is_imm_op(op);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational state-to-control decoder for the multicycle MIPS datapath
module mips_ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int STATE_W = 5
) (
  input  logic [STATE_W-1:0] state_bits,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [OPC_W-1:0]   funct,
  input  logic               branch_taken,
  output logic               pc_write_en,
  output logic               i_or_d,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [5:0]         alu_op,
  output logic               jump_and_link,
  output logic               is_signed,
  output logic               halted,
  output logic               illegal_op
);

  state_t state;
  assign state = state_t'(state_bits);

  always_comb begin
    pc_write_en   = 1'b0;
    i_or_d        = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REG;
    pc_source     = PC_SRC_ALU;
    alu_op        = ALU_OP_ADD;
    jump_and_link = 1'b0;
    is_signed     = 1'b0;
    halted        = 1'b0;
    illegal_op    = 1'b0;
    unique case (state)
      S_FETCH: alu_src_b = SRC_B_FOUR;
      // PC+4 computed combinationally through the ALU and loaded alongside IR
      S_FETCH_WAIT: begin
        alu_src_b   = SRC_B_FOUR;
        ir_write    = 1'b1;
        pc_write_en = 1'b1;
      end
      S_DECODE: begin
        alu_src_b  = SRC_B_SEXT_SH2;
        is_signed  = 1'b1;
        illegal_op = !is_known_op(opcode);
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_SEXT;
        is_signed = 1'b1;
      end
      S_LW_ACCESS, S_LW_WAIT: i_or_d = 1'b1;
      S_LW_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_SW_ACCESS: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a   = SRC_A_REG;
        alu_op      = ALU_OP_RTYPE;
        pc_write_en = (funct == FN_JR);
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_op    = ALU_OP_RTYPE;
      end
      S_I_EXEC: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_SEXT;
        alu_op    = opcode;
        is_signed = !is_logical_imm(opcode);
      end
      S_I_WB: begin
        reg_write = 1'b1;
        alu_op    = opcode;
        is_signed = !is_logical_imm(opcode);
      end
      S_BRANCH: begin
        alu_src_a   = SRC_A_REG;
        alu_op      = opcode;
        pc_source   = PC_SRC_ALU_OUT;
        pc_write_en = branch_taken;
      end
      S_JUMP: begin
        pc_source   = PC_SRC_JUMP;
        pc_write_en = 1'b1;
      end
      S_JAL_LINK: alu_op = ALU_OP_PASSA;
      S_JAL_WB: begin
        jump_and_link = 1'b1;
        reg_write     = 1'b1;
        pc_source     = PC_SRC_JUMP;
        pc_write_en   = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// rtl/mips_ctrl_fsm.sv - multicycle MIPS control FSM: state register, next-state logic, output decoder
module mips_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int STATE_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic [OPC_W-1:0] funct,
  input  logic             branch_taken,
  output logic             pc_write_en,
  output logic             i_or_d,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [5:0]       alu_op,
  output logic             jump_and_link,
  output logic             is_signed,
  output logic             halted,
  output logic             illegal_op
);

  state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      unique case (state)
        S_FETCH:      if (run) state <= S_FETCH_WAIT;
        S_FETCH_WAIT: state <= S_DECODE;
        S_DECODE: begin
          if (opcode == OP_LW || opcode == OP_SW) state <= S_MEM_ADDR;
          else if (opcode == OP_RTYPE)            state <= S_R_EXEC;
          else if (is_branch_op(opcode))          state <= S_BRANCH;
          else if (opcode == OP_J)                state <= S_JUMP;
          else if (opcode == OP_JAL)              state <= S_JAL_LINK;
          else if (is_imm_op(opcode))             state <= S_I_EXEC;
          else if (opcode == OP_HALT)             state <= S_HALT;
          else                                    state <= S_FETCH;
        end
        S_MEM_ADDR:   state <= (opcode == OP_LW) ? S_LW_ACCESS : S_SW_ACCESS;
        S_LW_ACCESS:  state <= S_LW_WAIT;
        S_LW_WAIT:    state <= S_LW_WB;
        // JR and the HI/LO-only multiplies retire without a register writeback
        S_R_EXEC: begin
          if (funct == FN_JR || funct == FN_MULT || funct == FN_MULTU) state <= S_FETCH;
          else state <= S_R_WB;
        end
        S_I_EXEC:     state <= S_I_WB;
        S_JAL_LINK:   state <= S_JAL_WB;
        S_HALT:       state <= S_HALT;
        default:      state <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_decode #(
    .OPC_W   (OPC_W),
    .STATE_W (STATE_W)
  ) u_decode (
    .state_bits    (STATE_W'(state)),
    .opcode        (opcode),
    .funct         (funct),
    .branch_taken  (branch_taken),
    .pc_write_en   (pc_write_en),
    .i_or_d        (i_or_d),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .jump_and_link (jump_and_link),
    .is_signed     (is_signed),
    .halted        (halted),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb/tb_mips_ctrl_fsm.sv - scoreboard bench: per-cycle expected control vectors for each instruction class
module tb_mips_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       branch_taken = 1'b0;
  logic       pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst, reg_write;
  logic       alu_src_a, jump_and_link, is_signed, halted, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [5:0] alu_op;

  int checks = 0;
  int passes = 0;
  logic [21:0] sb[$];
  logic [21:0] obs;
  logic [21:0] v_fetch, v_fw, v_dec;

  always #5 clk = ~clk;

  mips_ctrl_fsm #(.OPC_W(6), .STATE_W(5)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .branch_taken(branch_taken), .pc_write_en(pc_write_en), .i_or_d(i_or_d),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .ir_write(ir_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
    .jump_and_link(jump_and_link), .is_signed(is_signed), .halted(halted),
    .illegal_op(illegal_op)
  );

  assign obs = {pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst, reg_write,
                alu_src_a, alu_src_b, pc_source, alu_op, jump_and_link, is_signed, halted, illegal_op};

  function automatic logic [21:0] mk(input logic pcw, iord, mw, m2r, irw, rdst, rw, asa,
                                     input logic [1:0] asb, pcs, input logic [5:0] aop,
                                     input logic jal, sg, hlt, ill);
    return {pcw, iord, mw, m2r, irw, rdst, rw, asa, asb, pcs, aop, jal, sg, hlt, ill};
  endfunction

  task automatic test_reset();
    logic [21:0] e;
    rst = 1'b0;
    run = 1'b0;
    #2;
    checks++;
    if (obs !== v_fetch) $display("FAIL reset_state: got %h want %h", obs, v_fetch);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back(v_fetch);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = sb.pop_front();
      checks++;
      if (obs !== e) $display("FAIL run0_park cyc%0d: got %h want %h", i, obs, e);
      else passes++;
    end
  endtask

  task automatic test_lw();
    logic [21:0] e;
    int n;
    opcode = 6'h23;
    run = 1'b1;
    sb.push_back(v_fetch);
    sb.push_back(v_fw);
    sb.push_back(v_dec);
    sb.push_back(mk(0,0,0,0,0,0,0,1,2'b10,2'b00,6'h09,0,1,0,0));
    sb.push_back(mk(0,1,0,0,0,0,0,0,2'b00,2'b00,6'h09,0,0,0,0));
    sb.push_back(mk(0,1,0,0,0,0,0,0,2'b00,2'b00,6'h09,0,0,0,0));
    sb.push_back(mk(0,0,0,1,0,0,1,0,2'b00,2'b00,6'h09,0,0,0,0));
    sb.push_back(v_fetch);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == n - 1) run = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) $display("FAIL lw cyc%0d: got %h want %h", i + 1, obs, e);
      else passes++;
    end
  endtask

  task automatic test_branch(input logic taken);
    logic [21:0] e;
    int n;
    opcode = 6'h04;
    branch_taken = taken;
    run = 1'b1;
    sb.push_back(v_fetch);
    sb.push_back(v_fw);
    sb.push_back(v_dec);
    sb.push_back(mk(taken,0,0,0,0,0,0,1,2'b00,2'b01,6'h04,0,0,0,0));
    sb.push_back(v_fetch);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == n - 1) run = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) $display("FAIL beq_taken%0d cyc%0d: got %h want %h", taken, i + 1, obs, e);
      else passes++;
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_jal();
    logic [21:0] e;
    int n;
    opcode = 6'h03;
    run = 1'b1;
    sb.push_back(v_fetch);
    sb.push_back(v_fw);
    sb.push_back(v_dec);
    sb.push_back(mk(0,0,0,0,0,0,0,0,2'b00,2'b00,6'h3E,0,0,0,0));
    sb.push_back(mk(1,0,0,0,0,0,1,0,2'b00,2'b10,6'h09,1,0,0,0));
    sb.push_back(v_fetch);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == n - 1) run = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) $display("FAIL jal cyc%0d: got %h want %h", i + 1, obs, e);
      else passes++;
    end
  endtask

  task automatic test_ori();
    logic [21:0] e;
    int n;
    opcode = 6'h0D;
    run = 1'b1;
    sb.push_back(v_fetch);
    sb.push_back(v_fw);
    sb.push_back(v_dec);
    sb.push_back(mk(0,0,0,0,0,0,0,1,2'b10,2'b00,6'h0D,0,0,0,0));
    sb.push_back(mk(0,0,0,0,0,0,1,0,2'b00,2'b00,6'h0D,0,0,0,0));
    sb.push_back(v_fetch);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == n - 1) run = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) $display("FAIL ori cyc%0d: got %h want %h", i + 1, obs, e);
      else passes++;
    end
  endtask

  // MULT then MFLO with run held high, so the second fetch follows immediately
  task automatic test_back_to_back();
    logic [21:0] e;
    logic [21:0] r_exec;
    int n;
    opcode = 6'h00;
    funct = 6'h18;
    run = 1'b1;
    r_exec = mk(0,0,0,0,0,0,0,1,2'b00,2'b00,6'h00,0,0,0,0);
    sb.push_back(v_fetch);
    sb.push_back(v_fw);
    sb.push_back(v_dec);
    sb.push_back(r_exec);
    sb.push_back(v_fetch);
    sb.push_back(v_fw);
    sb.push_back(v_dec);
    sb.push_back(r_exec);
    sb.push_back(mk(0,0,0,0,0,1,1,0,2'b00,2'b00,6'h00,0,0,0,0));
    sb.push_back(v_fetch);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 4) funct = 6'h12;
      if (i == n - 1) run = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) $display("FAIL mult_mflo cyc%0d: got %h want %h", i + 1, obs, e);
      else passes++;
    end
  endtask

  task automatic test_illegal();
    logic [21:0] e;
    int n;
    opcode = 6'h3B;
    run = 1'b1;
    sb.push_back(v_fetch);
    sb.push_back(v_fw);
    sb.push_back(mk(0,0,0,0,0,0,0,0,2'b11,2'b00,6'h09,0,1,0,1));
    sb.push_back(v_fetch);
    sb.push_back(v_fetch);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == n - 2) run = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) $display("FAIL illegal cyc%0d: got %h want %h", i + 1, obs, e);
      else passes++;
    end
  endtask

  task automatic test_halt();
    logic [21:0] e;
    logic [21:0] v_halt;
    int n;
    opcode = 6'h3F;
    run = 1'b1;
    v_halt = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,6'h09,0,0,1,0);
    sb.push_back(v_fetch);
    sb.push_back(v_fw);
    sb.push_back(v_dec);
    for (int i = 0; i < 4; i++) sb.push_back(v_halt);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 4) run = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) $display("FAIL halt cyc%0d: got %h want %h", i + 1, obs, e);
      else passes++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== v_fetch) $display("FAIL halt_async_reset: got %h want %h", obs, v_fetch);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== v_fetch) $display("FAIL halt_after_reset: got %h want %h", obs, v_fetch);
    else passes++;
  endtask

  task automatic test_reset_mid_sw();
    logic [21:0] e;
    int n;
    opcode = 6'h2B;
    run = 1'b1;
    sb.push_back(v_fetch);
    sb.push_back(v_fw);
    sb.push_back(v_dec);
    sb.push_back(mk(0,0,0,0,0,0,0,1,2'b10,2'b00,6'h09,0,1,0,0));
    sb.push_back(mk(0,1,1,0,0,0,0,0,2'b00,2'b00,6'h09,0,0,0,0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = sb.pop_front();
      checks++;
      if (obs !== e) $display("FAIL sw cyc%0d: got %h want %h", i + 1, obs, e);
      else passes++;
    end
    run = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs !== v_fetch) $display("FAIL sw_abort: got %h want %h", obs, v_fetch);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    v_fetch = mk(0,0,0,0,0,0,0,0,2'b01,2'b00,6'h09,0,0,0,0);
    v_fw    = mk(1,0,0,0,1,0,0,0,2'b01,2'b00,6'h09,0,0,0,0);
    v_dec   = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,6'h09,0,1,0,0);
    test_reset();
    test_lw();
    test_branch(1'b0);
    test_branch(1'b1);
    test_jal();
    test_ori();
    test_back_to_back();
    test_illegal();
    test_reset_mid_sw();
    test_halt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_fsm.md
Name: mips_ctrl_fsm

Overview:
Multicycle control FSM that sequences the 32-bit MIPS datapath. It decodes the instruction register opcode and funct fields and walks fetch, decode, execute, memory and writeback states. It drives every datapath select and enable, combining branch_taken into pc_write_en. The top level instantiates it beside the datapath.

Parameters:
OPC_W, 6, opcode/funct field width
STATE_W, 5, state register width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
run  in  1  level; 0 parks the FSM in FETCH with all write enables low
opcode  in  6  ir_out[31:26]
funct  in  6  ir_out[5:0]
branch_taken  in  1  ALU compare result (combinational)
pc_write_en  out  1  PC load
i_or_d  out  1  0 = PC address, 1 = ALU_OUT address
mem_write  out  1  memory write strobe
mem_to_reg  out  1  1 = memory data to register file
ir_write  out  1  IR load
reg_dst  out  1  0 = rt, 1 = rd
reg_write  out  1  register-file write
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended, 11 = sign-extended << 2
pc_source  out  2  00 = ALU result, 01 = ALU_OUT, 10 = jump concat
alu_op  out  6  to alu_control
jump_and_link  out  1  force write address to r31
is_signed  out  1  sign- vs zero-extend imm16
halted  out  1  high in HALT
illegal_op  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset (rst = 0, async): state = FETCH. All outputs 0, except alu_op = ALU_OP_ADD and alu_src_b = 01, which are the FETCH decode values.
- Outputs are Moore-decoded from state. Exception: pc_write_en in BRANCH = branch_taken.
- Any output not listed for a state is 0, and alu_op defaults to ALU_OP_ADD.
- FETCH: i_or_d = 0; alu_src_a = 0; alu_src_b = 01. Moves to FETCH_WAIT only when run = 1.
- FETCH_WAIT: ir_write = 1, pc_write_en = 1, pc_source = 00, so PC <= PC + 4. Next state is DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, is_signed = 1, so ALU_OUT <= branch target. Next state by opcode:
  - LW or SW -> MEM_ADDR
  - R-type -> R_EXEC
  - BEQ, BNE, BLEZ, BGTZ -> BRANCH
  - J -> JUMP
  - JAL -> JAL_LINK
  - ADDIU, SLTI, SLTIU, ANDI, ORI, XORI -> I_EXEC
  - HALT -> HALT
  - anything else -> FETCH, with illegal_op = 1 for that cycle
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, is_signed = 1. Next state is LW_ACCESS or SW_ACCESS.
- LW_ACCESS: i_or_d = 1. Next state LW_WAIT (i_or_d = 1, synchronous read latency), then LW_WB.
- LW_WB: mem_to_reg = 1, reg_dst = 0, reg_write = 1. Next state is FETCH.
- SW_ACCESS: i_or_d = 1, mem_write = 1. Next state is FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 6'h00.
  - funct JR: also pc_write_en = 1, pc_source = 00; next state FETCH.
  - funct MULT or MULTU: next state FETCH (HI/LO only, no writeback).
  - otherwise: next state R_WB.
- R_WB: reg_dst = 1, reg_write = 1, alu_op = 6'h00 (keeps alu_lo_hi valid for MFHI/MFLO). Next state is FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = opcode. is_signed = 0 for ANDI, ORI, XORI; otherwise 1. Next state is I_WB.
- I_WB: reg_dst = 0, reg_write = 1; alu_op and is_signed held from I_EXEC. Next state is FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = opcode, pc_source = 01, pc_write_en = branch_taken. Next state is FETCH.
- JUMP: pc_source = 10, pc_write_en = 1. Next state is FETCH.
- JAL_LINK: alu_src_a = 0, alu_op = ALU_OP_PASSA, so ALU_OUT <= PC + 4. Next state is JAL_WB.
- JAL_WB: jump_and_link = 1, reg_write = 1, mem_to_reg = 0, pc_source = 10, pc_write_en = 1. Next state is FETCH.
- HALT: halted = 1 and all enables 0. Exits only on reset.
- Latencies in cycles: LW 7; SW, R-type and I-type 5; JAL 5; BRANCH, JUMP and JR 4.
- run only gates FETCH. An instruction already in flight always completes.
- Reset mid-instruction aborts immediately. No partial writes are issued after rst falls.
- Illegal encodings never assert reg_write, mem_write or pc_write_en.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum
  - opcode constants: OP_RTYPE 00, OP_J 02, OP_JAL 03, OP_BEQ 04, OP_BNE 05, OP_BLEZ 06, OP_BGTZ 07, OP_ADDIU 09, OP_SLTI 0A, OP_SLTIU 0B, OP_ANDI 0C, OP_ORI 0D, OP_XORI 0E, OP_LW 23, OP_SW 2B, OP_HALT 3F
  - funct constants: FN_JR 08, FN_MULT 18, FN_MULTU 19
  - ALU_OP_ADD = 6'h09, ALU_OP_PASSA = 6'h3E
  - mux-select localparams
- One sub-module: mips_ctrl_decode, a combinational state-to-output decoder. The FSM state register and next-state logic stay in the top.

Test Plan:
- Reset, release with run = 0 for 5 cycles -> state stays FETCH; ir_write and pc_write_en both 0 throughout.
- LW (opcode 23): cycle 2 ir_write = 1; cycles 5-6 i_or_d = 1; cycle 7 mem_to_reg = reg_write = 1; next fetch at cycle 8.
- BEQ with branch_taken = 0, then again with branch_taken = 1 -> pc_write_en in cycle 4 is 0, then 1; pc_source = 01 in both cases.
- JAL -> JAL_WB asserts jump_and_link = reg_write = pc_write_en = 1 with pc_source = 10; total 5 cycles.
- R-type MULT (funct 18), then MFLO (funct 12) -> MULT takes 4 cycles with no reg_write; MFLO takes 5 cycles with reg_dst = 1.
- Opcode 3F -> halted = 1 is sticky, and pulling rst low mid-HALT returns to FETCH. Opcode 3B -> illegal_op pulses once, no writes issued.
